evha_dmem_ptw_arb: RTL and testbench
====================================

EVHA_DMEM_PTW_ARB -- requirements
Module: evha_dmem_ptw_arb

Interface
REQ-001 SHALL have parameter PTW_MAX_RUN, default 4: maximum consecutive PTW grants while the LSU waits.
REQ-002 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have LSU requester ports:
- lsu_req_i  in  1  request
- lsu_cmd_i  in  type_scr1_mem_cmd_e  command
- lsu_width_i  in  type_scr1_mem_width_e  access width
- lsu_addr_i  in  SCR1_XLEN  address
- lsu_wdata_i  in  SCR1_XLEN  write data
REQ-005 SHALL have LSU response ports:
- lsu_rdy_o  out  1  response valid
- lsu_rdata_o  out  SCR1_XLEN  read data
- lsu_exc_o  out  1  access fault
REQ-006 SHALL have PTW requester ports:
- ptw_req_i  in  1  request
- ptw_cmd_i  in  type_scr1_mem_cmd_e  command
- ptw_addr_i  in  SCR1_XLEN  address
REQ-007 SHALL have PTW response ports:
- ptw_rdy_o  out  1  response valid
- ptw_rdata_o  out  SCR1_XLEN  read data
- ptw_exc_o  out  1  access fault
REQ-008 SHALL have DMEM master ports: dmem_req_o, dmem_cmd_o, dmem_width_o, dmem_addr_o, dmem_wdata_o (outputs), and dmem_rdy_i, dmem_rdata_i, dmem_exc_i (inputs), all SCR1 memif types and widths.

Function
REQ-009 SHALL implement FSM states IDLE, LSU_BUSY and PTW_BUSY.
REQ-010 SHALL pick the winner in IDLE by these rules:
- only one requester active: it wins
- both active: PTW wins, unless the run counter equals PTW_MAX_RUN, in which case LSU wins
REQ-011 SHALL, in IDLE, drive the winner's request onto DMEM combinationally in the same cycle (zero added latency).
REQ-012 SHALL force PTW width to SCR1_MEM_WIDTH_DWORD and PTW wdata to 0.
REQ-013 SHALL, when dmem_rdy_i is high in the grant cycle, complete the access and stay in IDLE.
REQ-014 SHALL, when dmem_rdy_i is low in the grant cycle, move to the winner's BUSY state.
REQ-015 SHALL, in a BUSY state:
- drive only the owner's request fields, registered at grant
- hold those fields stable until dmem_rdy_i
- ignore the non-owner
REQ-016 SHALL, on dmem_rdy_i in a BUSY state, return to IDLE; a new grant is possible the next cycle.
REQ-017 SHALL route responses to the owner only:
- rdy_o = dmem_rdy_i & owner
- exc_o = dmem_exc_i & owner
- rdata passed through unregistered
- non-owner rdy_o and exc_o held at 0
REQ-018 SHALL keep a run counter of width $clog2(PTW_MAX_RUN+1):
- increments on each PTW completion while lsu_req_i is high
- clears on any LSU completion
- clears on any cycle with lsu_req_i low
- saturates at PTW_MAX_RUN
REQ-019 SHALL treat requester deassertion after grant as ignored; the in-flight access completes and its response is still delivered.
REQ-020 SHALL treat simultaneous dmem_rdy_i and a new request in a BUSY state as completion only; the new request is arbitrated the next cycle.

Reset
REQ-021 SHALL, while rst_n is low:
- set state to IDLE and counter to 0
- hold all valid/rdy/exc outputs and dmem_req_o at 0, address/data outputs at 0
REQ-022 SHALL, on reset mid-transaction, drop the outstanding access with no response after release.

Structure
REQ-023 SHALL keep the FSM enum local; PTW_MAX_RUN stays a module parameter; no new package entries.
REQ-024 SHALL be a single module with no sub-modules; it is instantiated between the MMU wrapper PTW port, the LSU and the DMEM port.

Verification
REQ-025 SHALL check that lone LSU load 0x1000 with rdy same cycle -> dmem_addr 0x1000 in that cycle, lsu_rdy_o=1, ptw_rdy_o=0.
REQ-026 SHALL check that LSU and PTW requesting together, counter 0 -> PTW 0x8000_0000 granted, width DWORD; LSU served after PTW rdy.
REQ-027 SHALL check that PTW is held continuously with LSU waiting and PTW_MAX_RUN=4 -> 4 PTW completions, then LSU granted, counter cleared.
REQ-028 SHALL check that PTW is granted with 3-cycle rdy delay while ptw_addr_i changes -> dmem_addr held at the original value and the LSU is not granted.
REQ-029 SHALL check that dmem_exc_i on a PTW access -> ptw_exc_o=1, lsu_exc_o=0, FSM returns to IDLE.
REQ-030 SHALL check that rst_n is asserted in LSU_BUSY -> outputs 0 immediately; after release, no lsu_rdy_o until a new request.

Source files
------------

// File: rtl/evha_dmem_ptw_arb_pkg.sv
// Shared SCR1 memory-interface types used by the LSU, PTW and DMEM ports.
// DWORD is the width code used for page-table-walker fetches.
package evha_dmem_ptw_arb_pkg;

  localparam int SCR1_XLEN = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_DWORD = 2'b11
  } type_scr1_mem_width_e;

endpackage

// File: rtl/evha_dmem_ptw_arb.sv
// Two-requester DMEM arbiter: PTW has priority over LSU, with a bounded run of
// consecutive PTW grants so a waiting LSU cannot be starved.
module evha_dmem_ptw_arb
  import evha_dmem_ptw_arb_pkg::*;
#(
  parameter int PTW_MAX_RUN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // LSU
  input  logic                  lsu_req_i,
  input  type_scr1_mem_cmd_e    lsu_cmd_i,
  input  type_scr1_mem_width_e  lsu_width_i,
  input  logic [SCR1_XLEN-1:0]  lsu_addr_i,
  input  logic [SCR1_XLEN-1:0]  lsu_wdata_i,
  output logic                  lsu_rdy_o,
  output logic [SCR1_XLEN-1:0]  lsu_rdata_o,
  output logic                  lsu_exc_o,
  // PTW
  input  logic                  ptw_req_i,
  input  type_scr1_mem_cmd_e    ptw_cmd_i,
  input  logic [SCR1_XLEN-1:0]  ptw_addr_i,
  output logic                  ptw_rdy_o,
  output logic [SCR1_XLEN-1:0]  ptw_rdata_o,
  output logic                  ptw_exc_o,
  // DMEM master
  output logic                  dmem_req_o,
  output type_scr1_mem_cmd_e    dmem_cmd_o,
  output type_scr1_mem_width_e  dmem_width_o,
  output logic [SCR1_XLEN-1:0]  dmem_addr_o,
  output logic [SCR1_XLEN-1:0]  dmem_wdata_o,
  input  logic                  dmem_rdy_i,
  input  logic [SCR1_XLEN-1:0]  dmem_rdata_i,
  input  logic                  dmem_exc_i
);

  localparam int               CNT_W   = $clog2(PTW_MAX_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(PTW_MAX_RUN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LSU_BUSY = 2'd1,
    PTW_BUSY = 2'd2
  } state_e;

  state_e               state_reg, state_next;
  logic [CNT_W-1:0]     run_cnt_reg, run_cnt_next;
  type_scr1_mem_cmd_e   cmd_reg, cmd_next;
  type_scr1_mem_width_e width_reg, width_next;
  logic [SCR1_XLEN-1:0] addr_reg, addr_next;
  logic [SCR1_XLEN-1:0] wdata_reg, wdata_next;

  logic                 win_ptw, win_lsu, own_ptw, own_lsu, req_mux;
  type_scr1_mem_cmd_e   cmd_mux;
  type_scr1_mem_width_e width_mux;
  logic [SCR1_XLEN-1:0] addr_mux, wdata_mux;

  always_comb begin
    win_ptw = ptw_req_i & (~lsu_req_i | (run_cnt_reg != RUN_MAX));
    win_lsu = lsu_req_i & ~win_ptw;
    own_ptw = (state_reg == PTW_BUSY) | ((state_reg == IDLE) & win_ptw);
    own_lsu = (state_reg == LSU_BUSY) | ((state_reg == IDLE) & win_lsu);

    // Busy states replay the fields captured at grant; IDLE passes the winner through.
    req_mux   = (state_reg != IDLE) | win_ptw | win_lsu;
    cmd_mux   = cmd_reg;
    width_mux = width_reg;
    addr_mux  = addr_reg;
    wdata_mux = wdata_reg;
    if (state_reg == IDLE) begin
      if (win_ptw) begin
        cmd_mux   = ptw_cmd_i;
        width_mux = SCR1_MEM_WIDTH_DWORD;
        addr_mux  = ptw_addr_i;
        wdata_mux = '0;
      end else begin
        cmd_mux   = lsu_cmd_i;
        width_mux = lsu_width_i;
        addr_mux  = lsu_addr_i;
        wdata_mux = lsu_wdata_i;
      end
    end

    state_next = state_reg;
    cmd_next   = cmd_reg;
    width_next = width_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if ((win_ptw | win_lsu) & ~dmem_rdy_i) begin
          state_next = win_ptw ? PTW_BUSY : LSU_BUSY;
          cmd_next   = cmd_mux;
          width_next = width_mux;
          addr_next  = addr_mux;
          wdata_next = wdata_mux;
        end
      end
      default: begin
        if (dmem_rdy_i) state_next = IDLE;
      end
    endcase

    run_cnt_next = run_cnt_reg;
    if (~lsu_req_i || (own_lsu && dmem_rdy_i))
      run_cnt_next = '0;
    else if (own_ptw && dmem_rdy_i && run_cnt_reg != RUN_MAX)
      run_cnt_next = run_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      run_cnt_reg <= '0;
      cmd_reg     <= SCR1_MEM_CMD_RD;
      width_reg   <= SCR1_MEM_WIDTH_BYTE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      cmd_reg     <= cmd_next;
      width_reg   <= width_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
    end
  end

  // All outputs are combinational, so they are gated by rst_n to stay quiet during reset.
  always_comb begin
    dmem_req_o   = rst_n & req_mux;
    dmem_cmd_o   = rst_n ? cmd_mux : SCR1_MEM_CMD_RD;
    dmem_width_o = rst_n ? width_mux : SCR1_MEM_WIDTH_BYTE;
    dmem_addr_o  = rst_n ? addr_mux : '0;
    dmem_wdata_o = rst_n ? wdata_mux : '0;
    lsu_rdy_o    = rst_n & dmem_rdy_i & own_lsu;
    lsu_exc_o    = rst_n & dmem_exc_i & own_lsu;
    ptw_rdy_o    = rst_n & dmem_rdy_i & own_ptw;
    ptw_exc_o    = rst_n & dmem_exc_i & own_ptw;
    lsu_rdata_o  = rst_n ? dmem_rdata_i : '0;
    ptw_rdata_o  = rst_n ? dmem_rdata_i : '0;
  end

endmodule

// File: tb/tb_evha_dmem_ptw_arb.sv
// Directed bench for evha_dmem_ptw_arb: hand-computed expectations for grant
// order, field hold, response routing, run-limit fairness and reset behaviour.
module tb_evha_dmem_ptw_arb;
  import evha_dmem_ptw_arb_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 lsu_req_i, ptw_req_i;
  type_scr1_mem_cmd_e   lsu_cmd_i, ptw_cmd_i;
  type_scr1_mem_width_e lsu_width_i;
  logic [31:0]          lsu_addr_i, lsu_wdata_i, ptw_addr_i;
  logic                 lsu_rdy_o, lsu_exc_o, ptw_rdy_o, ptw_exc_o;
  logic [31:0]          lsu_rdata_o, ptw_rdata_o;
  logic                 dmem_req_o;
  type_scr1_mem_cmd_e   dmem_cmd_o;
  type_scr1_mem_width_e dmem_width_o;
  logic [31:0]          dmem_addr_o, dmem_wdata_o;
  logic                 dmem_rdy_i, dmem_exc_i;
  logic [31:0]          dmem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  evha_dmem_ptw_arb #(.PTW_MAX_RUN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_cmd_i(lsu_cmd_i), .lsu_width_i(lsu_width_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rdy_o(lsu_rdy_o), .lsu_rdata_o(lsu_rdata_o), .lsu_exc_o(lsu_exc_o),
    .ptw_req_i(ptw_req_i), .ptw_cmd_i(ptw_cmd_i), .ptw_addr_i(ptw_addr_i),
    .ptw_rdy_o(ptw_rdy_o), .ptw_rdata_o(ptw_rdata_o), .ptw_exc_o(ptw_exc_o),
    .dmem_req_o(dmem_req_o), .dmem_cmd_o(dmem_cmd_o), .dmem_width_o(dmem_width_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdy_i(dmem_rdy_i), .dmem_rdata_i(dmem_rdata_i), .dmem_exc_i(dmem_exc_i)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    lsu_req_i = 0; ptw_req_i = 0; dmem_rdy_i = 0; dmem_exc_i = 0;
  endtask

  task automatic idle();
    clear_inputs();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    lsu_cmd_i = SCR1_MEM_CMD_RD; lsu_width_i = SCR1_MEM_WIDTH_WORD;
    lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    ptw_cmd_i = SCR1_MEM_CMD_RD; ptw_addr_i = 32'h0; dmem_rdata_i = 32'h0;

    // Reset: requests and rdy asserted, outputs must stay at zero
    #2; lsu_req_i = 1; lsu_addr_i = 32'h0000_1111; dmem_rdy_i = 1; #1;
    $display("txn reset_hold");
    check("rst_dmem_req", dmem_req_o, 0);
    check("rst_dmem_addr", dmem_addr_o, 0);
    check("rst_lsu_rdy", lsu_rdy_o, 0);
    step(); step();
    clear_inputs();
    rst_n = 1;
    step();

    // Lone LSU load, ready in grant cycle
    $display("txn lsu_load 0x1000");
    lsu_req_i = 1; lsu_cmd_i = SCR1_MEM_CMD_RD; lsu_width_i = SCR1_MEM_WIDTH_WORD;
    lsu_addr_i = 32'h0000_1000; dmem_rdy_i = 1; dmem_rdata_i = 32'hCAFE_0001; #1;
    check("t1_req", dmem_req_o, 1);
    check("t1_addr", dmem_addr_o, 32'h0000_1000);
    check("t1_width", dmem_width_o, SCR1_MEM_WIDTH_WORD);
    check("t1_lsu_rdy", lsu_rdy_o, 1);
    check("t1_lsu_rdata", lsu_rdata_o, 32'hCAFE_0001);
    check("t1_ptw_rdy", ptw_rdy_o, 0);
    step();
    idle();

    // Both request, counter 0: PTW first (DWORD, wdata 0), then LSU write
    $display("txn ptw_vs_lsu 0x80000000");
    lsu_req_i = 1; lsu_cmd_i = SCR1_MEM_CMD_WR; lsu_width_i = SCR1_MEM_WIDTH_BYTE;
    lsu_addr_i = 32'h0000_2000; lsu_wdata_i = 32'h0000_DEAD;
    ptw_req_i = 1; ptw_cmd_i = SCR1_MEM_CMD_RD; ptw_addr_i = 32'h8000_0000; #1;
    check("t2_addr", dmem_addr_o, 32'h8000_0000);
    check("t2_width", dmem_width_o, SCR1_MEM_WIDTH_DWORD);
    check("t2_wdata", dmem_wdata_o, 0);
    check("t2_cmd", dmem_cmd_o, SCR1_MEM_CMD_RD);
    check("t2_ptw_rdy_wait", ptw_rdy_o, 0);
    step();
    ptw_req_i = 0; dmem_rdy_i = 1; dmem_rdata_i = 32'h0000_1234; #1;
    check("t2_busy_addr", dmem_addr_o, 32'h8000_0000);
    check("t2_ptw_rdy", ptw_rdy_o, 1);
    check("t2_ptw_rdata", ptw_rdata_o, 32'h0000_1234);
    check("t2_lsu_rdy_no", lsu_rdy_o, 0);
    step();
    $display("txn lsu_store 0x2000");
    #1;
    check("t2_lsu_addr", dmem_addr_o, 32'h0000_2000);
    check("t2_lsu_cmd", dmem_cmd_o, SCR1_MEM_CMD_WR);
    check("t2_lsu_width", dmem_width_o, SCR1_MEM_WIDTH_BYTE);
    check("t2_lsu_wdata", dmem_wdata_o, 32'h0000_DEAD);
    check("t2_lsu_rdy", lsu_rdy_o, 1);
    step();
    idle();

    // PTW run limit: four PTW completions, then LSU, then PTW again
    lsu_req_i = 1; lsu_cmd_i = SCR1_MEM_CMD_RD; lsu_width_i = SCR1_MEM_WIDTH_WORD;
    lsu_addr_i = 32'h0000_3000; ptw_req_i = 1; ptw_addr_i = 32'h8000_1000; dmem_rdy_i = 1;
    for (int i = 0; i < 4; i++) begin
      $display("txn ptw_run %0d", i);
      #1;
      check("t3_run_ptw_rdy", ptw_rdy_o, 1);
      check("t3_run_addr", dmem_addr_o, 32'h8000_1000);
      check("t3_run_lsu_rdy", lsu_rdy_o, 0);
      step();
    end
    $display("txn lsu_after_run 0x3000");
    #1;
    check("t3_lsu_addr", dmem_addr_o, 32'h0000_3000);
    check("t3_lsu_rdy", lsu_rdy_o, 1);
    check("t3_ptw_rdy", ptw_rdy_o, 0);
    step();
    $display("txn ptw_after_clear");
    #1;
    check("t3_cleared_addr", dmem_addr_o, 32'h8000_1000);
    check("t3_cleared_ptw_rdy", ptw_rdy_o, 1);
    step();
    idle();

    // PTW with 3-cycle rdy delay while ptw_addr_i moves; LSU must wait
    $display("txn ptw_slow 0x80002000");
    lsu_req_i = 1; lsu_addr_i = 32'h0000_4000; ptw_req_i = 1; ptw_addr_i = 32'h8000_2000; #1;
    check("t4_grant_addr", dmem_addr_o, 32'h8000_2000);
    step();
    ptw_addr_i = 32'h8000_3000; #1;
    check("t4_hold1_addr", dmem_addr_o, 32'h8000_2000);
    check("t4_hold1_lsu_rdy", lsu_rdy_o, 0);
    step();
    ptw_addr_i = 32'h8000_4000; #1;
    check("t4_hold2_addr", dmem_addr_o, 32'h8000_2000);
    check("t4_hold2_width", dmem_width_o, SCR1_MEM_WIDTH_DWORD);
    step();
    dmem_rdy_i = 1; #1;
    check("t4_done_addr", dmem_addr_o, 32'h8000_2000);
    check("t4_done_ptw_rdy", ptw_rdy_o, 1);
    check("t4_done_lsu_rdy", lsu_rdy_o, 0);
    step();
    $display("txn lsu_after_slow 0x4000");
    ptw_req_i = 0; #1;
    check("t4_lsu_addr", dmem_addr_o, 32'h0000_4000);
    check("t4_lsu_rdy", lsu_rdy_o, 1);
    step();
    idle();

    // Access fault on a busy PTW access, then FSM back in IDLE
    $display("txn ptw_exc 0x80005000");
    ptw_req_i = 1; ptw_addr_i = 32'h8000_5000;
    step();
    ptw_req_i = 0; dmem_rdy_i = 1; dmem_exc_i = 1; #1;
    check("t5_ptw_exc", ptw_exc_o, 1);
    check("t5_lsu_exc", lsu_exc_o, 0);
    check("t5_ptw_rdy", ptw_rdy_o, 1);
    step();
    $display("txn lsu_after_exc 0x1004");
    dmem_exc_i = 0; lsu_req_i = 1; lsu_addr_i = 32'h0000_1004; #1;
    check("t5_idle_lsu_rdy", lsu_rdy_o, 1);
    check("t5_idle_addr", dmem_addr_o, 32'h0000_1004);
    check("t5_idle_lsu_exc", lsu_exc_o, 0);
    step();
    idle();

    // Reset while in LSU_BUSY: access dropped, no late response
    $display("txn lsu_reset_mid 0x5000");
    lsu_req_i = 1; lsu_addr_i = 32'h0000_5000; #1;
    check("t6_grant_addr", dmem_addr_o, 32'h0000_5000);
    step();
    lsu_addr_i = 32'h0000_5555; #1;
    check("t6_busy_addr", dmem_addr_o, 32'h0000_5000);
    rst_n = 0; dmem_rdy_i = 1; #1;
    check("t6_rst_req", dmem_req_o, 0);
    check("t6_rst_addr", dmem_addr_o, 0);
    check("t6_rst_lsu_rdy", lsu_rdy_o, 0);
    step();
    rst_n = 1; lsu_req_i = 0; #1;
    check("t6_post_lsu_rdy", lsu_rdy_o, 0);
    check("t6_post_req", dmem_req_o, 0);
    step();
    $display("txn lsu_after_reset 0x6000");
    lsu_req_i = 1; lsu_addr_i = 32'h0000_6000; #1;
    check("t6_new_lsu_rdy", lsu_rdy_o, 1);
    check("t6_new_addr", dmem_addr_o, 32'h0000_6000);
    step();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
